// File: rtl/cache_pkg.sv
// cache_pkg
// Shared definitions for the cache-to-RAM bridge: default geometry of a cache
// line, the widths derived from that default geometry, and the bridge FSM
// state encoding.
package cache_pkg;

    // Default geometry (bytes addressed, words of WORD_W bits, LINE_WORDS per line)
    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_WORD_W     = 32;
    localparam int DEF_LINE_WORDS = 4;

    // Widths derived from the default geometry
    localparam int DEF_WORD_BYTES = DEF_WORD_W / 8;
    localparam int DEF_OFF_W      = $clog2(DEF_LINE_WORDS * DEF_WORD_BYTES);
    localparam int DEF_BEAT_W     = $clog2(DEF_LINE_WORDS);

    // Bridge sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WBEAT = 2'd1,
        ST_RBEAT = 2'd2,
        ST_RESP  = 2'd3
    } bridge_state_t;

endpackage

// File: rtl/line_buffer.sv
// line_buffer
// Holds one cache line of LINE_WORDS words. Word i occupies bits
// [i*WORD_W +: WORD_W]. The whole line can be loaded at once, or a single
// word selected by beat can be overwritten; the word selected by beat is
// always presented on rd_word.
// Ports:
//   clk, rst    clock, synchronous active-high reset (clears the line)
//   load        load the whole line from load_line (wins over wr_en)
//   load_line   line to load
//   wr_en       overwrite word[beat] with wr_word
//   beat        word index for write and read
//   wr_word     word to write
//   rd_word     word[beat] of the stored line
//   line_o      whole stored line
module line_buffer
    import cache_pkg::*;
#(
    parameter int  WORD_W     = DEF_WORD_W,
    parameter int  LINE_WORDS = DEF_LINE_WORDS,
    localparam int BEAT_W     = $clog2(LINE_WORDS),
    localparam int LINE_W     = WORD_W * LINE_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LINE_W-1:0] load_line,
    input  logic              wr_en,
    input  logic [BEAT_W-1:0] beat,
    input  logic [WORD_W-1:0] wr_word,
    output logic [WORD_W-1:0] rd_word,
    output logic [LINE_W-1:0] line_o
);

    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] line_d;

    // Next line contents: whole-line load, single word update, or hold
    always_comb begin
        line_d = line_q;
        if (load) begin
            line_d = load_line;
        end else if (wr_en) begin
            line_d[beat*WORD_W +: WORD_W] = wr_word;
        end else begin
            line_d = line_q;
        end
    end

    // Line storage register
    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign rd_word = line_q[beat*WORD_W +: WORD_W];
    assign line_o  = line_q;

endmodule

// File: rtl/cache_ram_bridge.sv
// cache_ram_bridge
// Turns one cache-line request (writeback or refill) from the cache controller
// into LINE_WORDS single-word RAM accesses over a req/ack handshake, then
// pulses response_ram_to_cache for one cycle. For refills the assembled line
// is presented on line_ram_to_cache and held until the next refill completes.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   enable_cache_to_ram      line request (sampled only in IDLE)
//   write_cache_to_ram       1 = writeback, 0 = refill
//   addr_cache_to_ram        line address (offset bits ignored)
//   line_cache_to_ram        writeback data
//   response_ram_to_cache    one-cycle completion pulse
//   line_ram_to_cache        refill data
//   busy                     high whenever not IDLE
//   ram_req/ram_we/ram_addr/ram_wdata   word access towards RAM
//   ram_rdata/ram_ack        word access completion from RAM
// All outputs come from registers or are decoded from registered state, so
// ram_ack may be combinationally derived from ram_req without forming a loop.
module cache_ram_bridge
    import cache_pkg::*;
#(
    parameter int  ADDR_W     = DEF_ADDR_W,
    parameter int  WORD_W     = DEF_WORD_W,
    parameter int  LINE_WORDS = DEF_LINE_WORDS,
    localparam int LINE_W     = WORD_W * LINE_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_cache_to_ram,
    input  logic              write_cache_to_ram,
    input  logic [ADDR_W-1:0] addr_cache_to_ram,
    input  logic [LINE_W-1:0] line_cache_to_ram,
    output logic              response_ram_to_cache,
    output logic [LINE_W-1:0] line_ram_to_cache,
    output logic              busy,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WORD_W-1:0] ram_wdata,
    input  logic [WORD_W-1:0] ram_rdata,
    input  logic              ram_ack
);

    localparam int WORD_BYTES = WORD_W / 8;
    localparam int OFF_W      = $clog2(LINE_WORDS * WORD_BYTES);
    localparam int BEAT_W     = $clog2(LINE_WORDS);
    localparam int BYTE_SH    = $clog2(WORD_BYTES);

    localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    bridge_state_t     state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LINE_W-1:0] line_out_q, line_out_d;

    logic              buf_load;
    logic              buf_wr;
    logic [WORD_W-1:0] buf_rd_word;
    logic [LINE_W-1:0] buf_line;
    logic [LINE_W-1:0] merged_line;

    line_buffer #(
        .WORD_W     (WORD_W),
        .LINE_WORDS (LINE_WORDS)
    ) u_line_buffer (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .load_line (line_cache_to_ram),
        .wr_en     (buf_wr),
        .beat      (beat_q),
        .wr_word   (ram_rdata),
        .rd_word   (buf_rd_word),
        .line_o    (buf_line)
    );

    // Refill line as it will look once the current read word is captured;
    // lets the output line be valid in the same cycle as the response pulse
    always_comb begin
        merged_line = buf_line;
        merged_line[beat_q*WORD_W +: WORD_W] = ram_rdata;
    end

    // Next-state and sequencing control
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        base_d     = base_q;
        line_out_d = line_out_q;
        buf_load   = 1'b0;
        buf_wr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_cache_to_ram) begin
                    base_d   = addr_cache_to_ram & LINE_MASK;
                    beat_d   = '0;
                    buf_load = 1'b1;
                    if (write_cache_to_ram) begin
                        state_d = ST_WBEAT;
                    end else begin
                        state_d = ST_RBEAT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WBEAT, ST_RBEAT: begin
                if (ram_ack) begin
                    buf_wr = (state_q == ST_RBEAT);
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_RESP;
                        if (state_q == ST_RBEAT) begin
                            line_out_d = merged_line;
                        end else begin
                            line_out_d = line_out_q;
                        end
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                        state_d = state_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, beat counter, line base and refill output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            base_q     <= '0;
            line_out_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            base_q     <= base_d;
            line_out_q <= line_out_d;
        end
    end

    // The beat offset is OR-ed into the cleared offset field, so it can
    // never carry into the line address bits.
    assign ram_req               = (state_q == ST_WBEAT) || (state_q == ST_RBEAT);
    assign ram_we                = (state_q == ST_WBEAT);
    assign ram_addr              = base_q | (ADDR_W'(beat_q) << BYTE_SH);
    assign ram_wdata             = buf_rd_word;
    assign response_ram_to_cache = (state_q == ST_RESP);
    assign busy                  = (state_q != ST_IDLE);
    assign line_ram_to_cache     = line_out_q;

endmodule

// File: tb/tb_cache_ram_bridge.sv
// tb_cache_ram_bridge
// Directed bench for cache_ram_bridge. A behavioural RAM returns the byte
// address as read data and acknowledges combinationally when allowed.
// Expected RAM writes and expected response lines are queued when a request
// is issued and compared when the bridge produces them.
module tb_cache_ram_bridge;
    import cache_pkg::*;

    localparam int AW     = DEF_ADDR_W;
    localparam int WW     = DEF_WORD_W;
    localparam int LW     = DEF_LINE_WORDS;
    localparam int LINE_W = WW * LW;

    typedef struct {
        logic [AW-1:0] a;
        logic [WW-1:0] d;
    } wr_t;

    logic              clk;
    logic              rst;
    logic              enable_cache_to_ram;
    logic              write_cache_to_ram;
    logic [AW-1:0]     addr_cache_to_ram;
    logic [LINE_W-1:0] line_cache_to_ram;
    logic              response_ram_to_cache;
    logic [LINE_W-1:0] line_ram_to_cache;
    logic              busy;
    logic              ram_req;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [WW-1:0]     ram_wdata;
    logic [WW-1:0]     ram_rdata;
    logic              ram_ack;

    logic              ack_en;
    logic              spur_ack;

    int                n_cmp = 0;
    int                n_bad = 0;
    wr_t               exp_wr[$];
    logic [LINE_W-1:0] exp_resp[$];
    logic [LINE_W-1:0] hold_line;

    cache_ram_bridge dut (
        .clk                   (clk),
        .rst                   (rst),
        .enable_cache_to_ram   (enable_cache_to_ram),
        .write_cache_to_ram    (write_cache_to_ram),
        .addr_cache_to_ram     (addr_cache_to_ram),
        .line_cache_to_ram     (line_cache_to_ram),
        .response_ram_to_cache (response_ram_to_cache),
        .line_ram_to_cache     (line_ram_to_cache),
        .busy                  (busy),
        .ram_req               (ram_req),
        .ram_we                (ram_we),
        .ram_addr              (ram_addr),
        .ram_wdata             (ram_wdata),
        .ram_rdata             (ram_rdata),
        .ram_ack               (ram_ack)
    );

    // RAM model: word at byte address A holds A
    assign ram_ack   = (ram_req & ack_en) | spur_ack;
    assign ram_rdata = WW'(ram_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] line_base(input logic [AW-1:0] addr);
        line_base = addr & ~((AW'(1) << DEF_OFF_W) - AW'(1));
    endfunction

    // Line a refill at addr must return from the RAM model
    function automatic logic [LINE_W-1:0] ref_line(input logic [AW-1:0] addr);
        ref_line = '0;
        for (int i = 0; i < (1 << DEF_BEAT_W); i++) begin
            ref_line[i*WW +: WW] = WW'(line_base(addr) + AW'(i * DEF_WORD_BYTES));
        end
    endfunction

    task automatic push_writes(input logic [AW-1:0] addr, input logic [LINE_W-1:0] line);
        wr_t w;
        for (int i = 0; i < LW; i++) begin
            w.a = line_base(addr) + AW'(i * DEF_WORD_BYTES);
            w.d = line[i*WW +: WW];
            exp_wr.push_back(w);
        end
    endtask

    // Scoreboard check of what the DUT presents in the current cycle
    task automatic monitor();
        wr_t               w;
        logic [LINE_W-1:0] e;
        if (ram_req && ram_we && ram_ack) begin
            if (exp_wr.size() > 0) begin
                w = exp_wr.pop_front();
                chk("wr_addr", LINE_W'(ram_addr), LINE_W'(w.a));
                chk("wr_data", LINE_W'(ram_wdata), LINE_W'(w.d));
            end else begin
                chk("spurious_write", LINE_W'(ram_we), LINE_W'(1'b0));
            end
        end
        if (response_ram_to_cache) begin
            if (exp_resp.size() > 0) begin
                e = exp_resp.pop_front();
                chk("resp_line", line_ram_to_cache, e);
            end else begin
                chk("spurious_resp", LINE_W'(response_ram_to_cache), LINE_W'(1'b0));
            end
        end
    endtask

    // Check the current cycle, then advance to 1 time unit after the next edge
    task automatic step();
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input int max, output int n);
        n = 0;
        while (response_ram_to_cache !== 1'b1 && n < max) begin
            step();
            n++;
        end
        if (response_ram_to_cache !== 1'b1) begin
            chk("resp_timeout", LINE_W'(response_ram_to_cache), LINE_W'(1'b1));
        end
    endtask

    task automatic idle_quiet(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            chk({tag, "_resp"}, LINE_W'(response_ram_to_cache), LINE_W'(1'b0));
            chk({tag, "_busy"}, LINE_W'(busy), LINE_W'(1'b0));
            chk({tag, "_req"}, LINE_W'(ram_req), LINE_W'(1'b0));
            step();
        end
    endtask

    initial begin
        int n;
        logic [LINE_W-1:0] wb_line;

        rst                 = 1'b1;
        enable_cache_to_ram = 1'b0;
        write_cache_to_ram  = 1'b0;
        addr_cache_to_ram   = '0;
        line_cache_to_ram   = '0;
        ack_en              = 1'b1;
        spur_ack            = 1'b0;
        hold_line           = '0;
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_resp", LINE_W'(response_ram_to_cache), LINE_W'(1'b0));
        chk("rst_busy", LINE_W'(busy), LINE_W'(1'b0));
        chk("rst_req", LINE_W'(ram_req), LINE_W'(1'b0));
        chk("rst_we", LINE_W'(ram_we), LINE_W'(1'b0));
        chk("rst_addr", LINE_W'(ram_addr), LINE_W'(0));
        chk("rst_wdata", LINE_W'(ram_wdata), LINE_W'(0));
        chk("rst_line", line_ram_to_cache, LINE_W'(0));

        // Refill at 0x1234 with zero-wait RAM
        enable_cache_to_ram = 1'b1;
        write_cache_to_ram  = 1'b0;
        addr_cache_to_ram   = 32'h0000_1234;
        line_cache_to_ram   = {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};
        hold_line           = ref_line(32'h0000_1234);
        exp_resp.push_back(hold_line);
        step();
        enable_cache_to_ram = 1'b0;
        for (int i = 0; i < LW; i++) begin
            chk("refill_req", LINE_W'(ram_req), LINE_W'(1'b1));
            chk("refill_we", LINE_W'(ram_we), LINE_W'(1'b0));
            chk("refill_busy", LINE_W'(busy), LINE_W'(1'b1));
            chk("refill_resp_early", LINE_W'(response_ram_to_cache), LINE_W'(1'b0));
            chk("refill_addr", LINE_W'(ram_addr), LINE_W'(32'h0000_1230 + 32'(i * 4)));
            step();
        end
        chk("refill_resp", LINE_W'(response_ram_to_cache), LINE_W'(1'b1));
        chk("refill_resp_busy", LINE_W'(busy), LINE_W'(1'b1));
        chk("refill_resp_req", LINE_W'(ram_req), LINE_W'(1'b0));
        step();
        chk("refill_after_resp", LINE_W'(response_ram_to_cache), LINE_W'(1'b0));
        chk("refill_after_busy", LINE_W'(busy), LINE_W'(1'b0));

        // Writeback at 0x40; refill line must stay unchanged
        wb_line             = {32'h0000_000D, 32'h0000_000C, 32'h0000_000B, 32'h0000_000A};
        enable_cache_to_ram = 1'b1;
        write_cache_to_ram  = 1'b1;
        addr_cache_to_ram   = 32'h0000_0040;
        line_cache_to_ram   = wb_line;
        push_writes(32'h0000_0040, wb_line);
        exp_resp.push_back(hold_line);
        step();
        enable_cache_to_ram = 1'b0;
        line_cache_to_ram   = '0;
        chk("wb_we", LINE_W'(ram_we), LINE_W'(1'b1));
        wait_resp(20, n);
        chk("wb_latency", LINE_W'(n), LINE_W'(4));
        step();
        chk("wb_after_resp", LINE_W'(response_ram_to_cache), LINE_W'(1'b0));

        // Writeback at 0x2008 with two wait states on beat 1
        wb_line             = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        enable_cache_to_ram = 1'b1;
        write_cache_to_ram  = 1'b1;
        addr_cache_to_ram   = 32'h0000_2008;
        line_cache_to_ram   = wb_line;
        push_writes(32'h0000_2008, wb_line);
        exp_resp.push_back(hold_line);
        step();
        enable_cache_to_ram = 1'b0;
        line_cache_to_ram   = '0;
        step();
        ack_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("stall_req", LINE_W'(ram_req), LINE_W'(1'b1));
            chk("stall_addr", LINE_W'(ram_addr), LINE_W'(32'h0000_2004));
            chk("stall_wdata", LINE_W'(ram_wdata), LINE_W'(32'h2222_2222));
            step();
        end
        ack_en = 1'b1;
        wait_resp(20, n);
        chk("stall_latency", LINE_W'(3 + n), LINE_W'(6));
        step();

        // Enable held and toggled mid-transaction; still high one cycle past response
        enable_cache_to_ram = 1'b1;
        write_cache_to_ram  = 1'b0;
        addr_cache_to_ram   = 32'h0000_0080;
        exp_resp.push_back(ref_line(32'h0000_0080));
        step();
        step();
        enable_cache_to_ram = 1'b0;
        step();
        enable_cache_to_ram = 1'b1;
        write_cache_to_ram  = 1'b1;
        addr_cache_to_ram   = 32'h0000_00C4;
        step();
        enable_cache_to_ram = 1'b0;
        chk("toggle_we", LINE_W'(ram_we), LINE_W'(1'b0));
        step();
        enable_cache_to_ram = 1'b1;
        write_cache_to_ram  = 1'b0;
        chk("toggle_resp", LINE_W'(response_ram_to_cache), LINE_W'(1'b1));
        hold_line = ref_line(32'h0000_00C4);
        exp_resp.push_back(hold_line);
        step();
        chk("b2b_idle_busy", LINE_W'(busy), LINE_W'(1'b0));
        chk("b2b_idle_resp", LINE_W'(response_ram_to_cache), LINE_W'(1'b0));
        step();
        enable_cache_to_ram = 1'b0;
        chk("b2b_addr", LINE_W'(ram_addr), LINE_W'(32'h0000_00C0));
        wait_resp(20, n);
        chk("b2b_latency", LINE_W'(n), LINE_W'(4));
        step();
        idle_quiet(3, "b2b_quiet");

        // Reset during beat 2 of a refill
        enable_cache_to_ram = 1'b1;
        write_cache_to_ram  = 1'b0;
        addr_cache_to_ram   = 32'h0000_0300;
        step();
        enable_cache_to_ram = 1'b0;
        step();
        step();
        chk("abort_beat2_addr", LINE_W'(ram_addr), LINE_W'(32'h0000_0308));
        rst = 1'b1;
        step();
        rst       = 1'b0;
        hold_line = '0;
        chk("abort_req", LINE_W'(ram_req), LINE_W'(1'b0));
        chk("abort_addr", LINE_W'(ram_addr), LINE_W'(0));
        chk("abort_wdata", LINE_W'(ram_wdata), LINE_W'(0));
        chk("abort_line", line_ram_to_cache, LINE_W'(0));
        idle_quiet(3, "abort_quiet");

        // Fresh refill after the abort
        enable_cache_to_ram = 1'b1;
        write_cache_to_ram  = 1'b0;
        addr_cache_to_ram   = 32'h0000_0504;
        hold_line           = ref_line(32'h0000_0504);
        exp_resp.push_back(hold_line);
        step();
        enable_cache_to_ram = 1'b0;
        wait_resp(20, n);
        chk("fresh_latency", LINE_W'(n), LINE_W'(4));
        step();

        // Spurious ram_ack while idle
        spur_ack = 1'b1;
        idle_quiet(3, "spur");
        spur_ack = 1'b0;
        chk("spur_line_held", line_ram_to_cache, hold_line);

        chk("wr_queue_left", LINE_W'(exp_wr.size()), LINE_W'(0));
        chk("resp_queue_left", LINE_W'(exp_resp.size()), LINE_W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
